uart_packet_rx: RTL
===================

Name: uart_packet_rx

Overview:
Parametrised UART packet receiver and write demultiplexer, the next generation of the board's serial load path. It receives 8N1 bytes at a configurable bit period and parses packets with a configurable address width. It emits one write strobe per data byte, auto-incrementing the address from a packet base address. It adds false-start rejection, framing and inter-byte timeout detection, and per-packet completion status. The block sits between the board UART pin and the memory/register loader.

Parameters:
CLKS_PER_BIT, 100, clock cycles per UART bit; minimum 8.
ADDR_W, 8, write address width; must be 8, 16, 24 or 32.
TIMEOUT_BITS, 40, maximum idle gap between bytes inside a packet, in bit periods.

Ports:
clk  in  1  system clock.
RESET_N  in  1  reset, asynchronous, active-low.
uart_rx  in  1  serial input, idle high, asynchronous to clk.
clear_errors  in  1  one-cycle pulse that clears the sticky error flags.
wr_addr  out  ADDR_W  write address.
wr_data  out  8  write data.
wr_en  out  1  one-cycle write strobe.
pkt_done  out  1  one-cycle pulse marking the final write of a packet.
pkt_ok  out  1  checksum result, valid while pkt_done is high.
frame_error  out  1  sticky: stop bit was sampled low.
checksum_error  out  1  sticky: a packet's checksum failed.
timeout_error  out  1  sticky: a packet was aborted by inter-byte timeout.

Behaviour:
- Reset (RESET_N=0, asynchronous):
  - All outputs 0; synchroniser flops 1; receiver in IDLE; parser in CKSUM.
  - Deassertion mid-byte or mid-packet: the partial byte or packet is discarded; no spurious strobe.
- Input conditioning: uart_rx passes through a 2-flop synchroniser, and all sampling uses the synchronised value.
- Receiver FSM:
  - IDLE: on synchronised line = 0, load the bit counter with CLKS_PER_BIT/2-1 and go to START.
  - START: when the counter reaches 0, sample the line. 1 → false start, return to IDLE with no error. 0 → go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first.
  - STOP: sample after one more CLKS_PER_BIT.
    - Stop = 1 → internal byte_valid pulses for 1 cycle, then IDLE.
    - Stop = 0 → set frame_error, drop the byte, abort the parser to CKSUM, go to BREAK.
  - BREAK: wait for the line to return to 1, then IDLE.
- Packet format: checksum byte | ADDR_W/8 address bytes, MSB first | count byte | count+1 data bytes.
- Parser FSM:
  - CKSUM: sum ← byte → ADDR.
  - ADDR: shift the byte into base; after ADDR_W/8 bytes → COUNT.
  - COUNT: remaining ← byte → DATA.
  - DATA: on each byte, register wr_data and wr_addr and assert wr_en.
    - wr_addr = base for the first data byte, then +1 per byte, modulo 2^ADDR_W (wraps).
    - On the byte with remaining = 0: pulse pkt_done with the same wr_en; pkt_ok = (sum + byte)[7:0] == 0; if not ok, set checksum_error; → CKSUM.
  - Every byte other than the first adds into the 8-bit sum, modulo 256.
- Latency: wr_en, wr_data and wr_addr are registered and assert exactly 1 clk after byte_valid. wr_addr and wr_data hold their values until the next write.
- Count byte 0x00 means 1 data byte; 0xFF means 256 data bytes.
- Timeout:
  - The counter runs while the parser is outside CKSUM and restarts on every byte_valid.
  - When it reaches TIMEOUT_BITS*CLKS_PER_BIT: set timeout_error, parser → CKSUM, no pkt_done.
  - The counter must be wide enough for that product; it is not running in CKSUM.
- Sticky flags: clear_errors clears all three flags. If a set event coincides with clear_errors, set wins.
- Writes already issued from a packet that later fails its checksum are not retracted. The consumer uses pkt_ok to decide whether to commit.

Test Plan:
- Basic packet (CLKS_PER_BIT=16, ADDR_W=8): bytes BD 10 02 AA BB CC → writes (0x10,AA), (0x11,BB), (0x12,CC). pkt_done and pkt_ok=1 coincide with the third wr_en; no error flags.
- Bad checksum: same packet with first byte BE → same three writes; pkt_ok=0; checksum_error=1. clear_errors pulse → checksum_error=0.
- False start: uart_rx low for 4 clks only → no byte_valid, no wr_en, all flags 0. A following valid packet is received correctly.
- Framing error: stop bit of the count byte driven 0 → frame_error=1, no writes. A subsequent valid packet is written normally.
- Address wrap (ADDR_W=16): bytes FE FF FF 01 01 02 → writes (0xFFFF,01), (0x0000,02); pkt_ok=1.
- Timeout and reset: send only BD 10, then idle >40 bit periods → timeout_error=1, parser back in CKSUM. Assert RESET_N=0 mid-byte of a later packet → all outputs 0 immediately; no wr_en after release.

Source files
------------

// File: rtl/uart_packet_rx.sv
// 8N1 UART receiver feeding a packet parser that turns data bytes into auto-incrementing writes.
// Packet: checksum | address bytes (MSB first) | count | count+1 data bytes.
module uart_packet_rx #(
  parameter int unsigned CLKS_PER_BIT = 100,
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned TIMEOUT_BITS = 40
) (
  input  logic              clk,
  input  logic              RESET_N,
  input  logic              uart_rx,
  input  logic              clear_errors,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              wr_en,
  output logic              pkt_done,
  output logic              pkt_ok,
  output logic              frame_error,
  output logic              checksum_error,
  output logic              timeout_error
);

  localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int unsigned TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TO_W     = $clog2(TO_LIMIT + 1);
  localparam int unsigned NBYTES   = ADDR_W / 8;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
  typedef enum logic [1:0] {P_CKSUM, P_ADDR, P_COUNT, P_DATA} p_state_t;

  logic              rx_meta, rx_sync;
  rx_state_t         rx_state, rx_state_n;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
  logic [2:0]        bit_idx, bit_idx_n;
  logic [7:0]        rx_shift, rx_shift_n;
  logic              byte_valid_c, frame_err_c;

  p_state_t          p_state, p_state_n;
  logic [7:0]        sum, sum_n, remaining, remaining_n;
  logic [ADDR_W-1:0] base, base_n;
  logic [1:0]        addr_idx, addr_idx_n;
  logic [TO_W-1:0]   to_cnt, to_cnt_n;
  logic              timeout_c, wr_en_c, done_c, ok_c, cks_err_c;

  // Two-flop synchroniser; idles high out of reset.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      rx_state <= RX_IDLE;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_n;
      bit_cnt  <= bit_cnt_n;
      bit_idx  <= bit_idx_n;
      rx_shift <= rx_shift_n;
    end
  end

  // Receiver: start bit checked at mid-bit, then one sample per bit period.
  always_comb begin
    rx_state_n   = rx_state;
    bit_cnt_n    = (bit_cnt == '0) ? '0 : bit_cnt - CNT_W'(1);
    bit_idx_n    = bit_idx;
    rx_shift_n   = rx_shift;
    byte_valid_c = 1'b0;
    frame_err_c  = 1'b0;
    case (rx_state)
      RX_IDLE: if (!rx_sync) begin
        bit_cnt_n  = CNT_W'(CLKS_PER_BIT / 2 - 1);
        rx_state_n = RX_START;
      end
      RX_START: if (bit_cnt == '0) begin
        if (rx_sync) begin
          rx_state_n = RX_IDLE;
        end else begin
          bit_cnt_n  = CNT_W'(CLKS_PER_BIT - 1);
          bit_idx_n  = '0;
          rx_state_n = RX_DATA;
        end
      end
      RX_DATA: if (bit_cnt == '0) begin
        rx_shift_n = {rx_sync, rx_shift[7:1]};
        bit_cnt_n  = CNT_W'(CLKS_PER_BIT - 1);
        if (bit_idx == 3'd7) rx_state_n = RX_STOP;
        else                 bit_idx_n  = bit_idx + 3'd1;
      end
      RX_STOP: if (bit_cnt == '0) begin
        if (rx_sync) begin
          byte_valid_c = 1'b1;
          rx_state_n   = RX_IDLE;
        end else begin
          frame_err_c = 1'b1;
          rx_state_n  = RX_BREAK;
        end
      end
      RX_BREAK: if (rx_sync) rx_state_n = RX_IDLE;
      default: rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      p_state        <= P_CKSUM;
      sum            <= '0;
      remaining      <= '0;
      base           <= '0;
      addr_idx       <= '0;
      to_cnt         <= '0;
      wr_addr        <= '0;
      wr_data        <= '0;
      wr_en          <= 1'b0;
      pkt_done       <= 1'b0;
      pkt_ok         <= 1'b0;
      frame_error    <= 1'b0;
      checksum_error <= 1'b0;
      timeout_error  <= 1'b0;
    end else begin
      p_state   <= p_state_n;
      sum       <= sum_n;
      remaining <= remaining_n;
      base      <= base_n;
      addr_idx  <= addr_idx_n;
      to_cnt    <= to_cnt_n;
      wr_en     <= wr_en_c;
      pkt_done  <= done_c;
      pkt_ok    <= ok_c;
      if (wr_en_c) begin
        wr_addr <= base;
        wr_data <= rx_shift;
      end
      // Sticky flags: a set event beats a simultaneous clear.
      if (frame_err_c)       frame_error <= 1'b1;
      else if (clear_errors) frame_error <= 1'b0;
      if (cks_err_c)         checksum_error <= 1'b1;
      else if (clear_errors) checksum_error <= 1'b0;
      if (timeout_c)         timeout_error <= 1'b1;
      else if (clear_errors) timeout_error <= 1'b0;
    end
  end

  // Parser; a framing error or inter-byte timeout drops the packet back to CKSUM.
  always_comb begin
    p_state_n   = p_state;
    sum_n       = sum;
    remaining_n = remaining;
    base_n      = base;
    addr_idx_n  = addr_idx;
    wr_en_c     = 1'b0;
    done_c      = 1'b0;
    ok_c        = 1'b0;
    cks_err_c   = 1'b0;
    timeout_c   = (p_state != P_CKSUM) && !byte_valid_c && (to_cnt == TO_W'(TO_LIMIT));
    to_cnt_n    = (p_state == P_CKSUM || byte_valid_c || timeout_c) ? '0 : to_cnt + TO_W'(1);
    if (frame_err_c || timeout_c) begin
      p_state_n = P_CKSUM;
    end else if (byte_valid_c) begin
      sum_n = sum + rx_shift;
      case (p_state)
        P_CKSUM: begin
          sum_n      = rx_shift;
          addr_idx_n = '0;
          p_state_n  = P_ADDR;
        end
        P_ADDR: begin
          base_n     = (base << 8) | ADDR_W'(rx_shift);
          addr_idx_n = addr_idx + 2'd1;
          if (addr_idx == 2'(NBYTES - 1)) p_state_n = P_COUNT;
        end
        P_COUNT: begin
          remaining_n = rx_shift;
          p_state_n   = P_DATA;
        end
        P_DATA: begin
          wr_en_c = 1'b1;
          base_n  = base + ADDR_W'(1);
          if (remaining == '0) begin
            done_c    = 1'b1;
            ok_c      = (sum_n == 8'h00);
            cks_err_c = !ok_c;
            p_state_n = P_CKSUM;
          end else begin
            remaining_n = remaining - 8'd1;
          end
        end
        default: p_state_n = P_CKSUM;
      endcase
    end
  end

endmodule
